uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART bit-rate counter.
- Detects the start bit on the serial line and asserts count_sig to run the rate counter.
- Samples rx on each mid-bit bps_clk strobe, assembles the character LSB first and checks the stop bit.
- Delivers each byte through a one-entry valid/ready holding register, with framing-error and overrun flags.

Parameters:
- DATA_BITS, 8, data bits per character (legal range 5..8).
- SYNC_STAGES, 2, flip-flop stages on rx before use (minimum 2).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous to clk, idles high
- bps_clk  input  1  one-cycle mid-bit strobe from the rate counter
- count_sig  output  1  enables the rate counter; while low the counter is held at 0
- rx_data  output  DATA_BITS  received character, right-aligned
- rx_valid  output  1  rx_data holds an unconsumed character
- rx_ready  input  1  consumer accepts rx_data in this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: character dropped because the holding register was full

Behaviour:
- Reset: clk and rstn as named above; one clock; reset is asynchronous and active-low.
- Reset values: synchronizer stages = 1, state = IDLE, count_sig = 0, rx_data = 0, rx_valid = 0, frame_err = 0, overrun = 0, shift register = 0, bit counter = 0.
- Synchronizer: rx passes through SYNC_STAGES flops; rx_s is the last stage. A falling edge is rx_s = 0 with previous rx_s = 1.
- Rate counter timing contract: first bps_clk arrives 1042 cycles after count_sig rises, then every 2083 cycles while count_sig stays high.
- IDLE: count_sig = 0. On a falling edge, go to START and set count_sig = 1 on the next clock.
- START, on bps_clk:
  - rx_s = 0: clear bit counter, go to DATA.
  - rx_s = 1 (false start / glitch): go to IDLE, count_sig = 0. No flags raised.
- DATA, on each bps_clk: shift rx_s into the MSB of the DATA_BITS shift register (right shift), increment bit counter. After the DATA_BITS-th sample, go to STOP.
- STOP, on bps_clk (then always go to IDLE, count_sig = 0 on the next clock):
  - rx_s = 1: deliver the character (see holding register).
  - rx_s = 0: pulse frame_err for 1 cycle, discard the character, leave rx_valid and rx_data unchanged.
- Falling edges while not in IDLE are ignored.
- A start edge 1 cycle after returning to IDLE is accepted. The line is still high at stop mid-bit, so no edge is lost.
- Holding register delivery:
  - rx_valid = 0: rx_data <= shift register, rx_valid = 1 in the cycle after the stop bps_clk.
  - rx_valid = 1 and rx_ready = 1 in the same cycle: new data loaded, rx_valid stays 1, no overrun.
  - rx_valid = 1 and rx_ready = 0: new character dropped, old rx_data kept, overrun pulses 1 cycle.
- Consumption: rx_valid && rx_ready with no delivery in that cycle clears rx_valid next cycle. rx_ready while rx_valid = 0 has no effect.
- bps_clk in IDLE is ignored.
- Reset mid-frame: all state returns to reset values immediately; the partial character is lost.
- Latency: rx_valid rises 1 cycle after the stop-bit bps_clk.

Test Plan:
- Byte 0x55, 8N1 at 2083 cycles/bit, rx_ready = 1 -> count_sig rises 1 cycle after the synchronized edge; rx_data = 0x55, rx_valid high for 1 cycle; no flags; count_sig = 0 after stop.
- rx low for 500 cycles, then high -> START samples 1; back to IDLE; rx_valid, frame_err and overrun all stay 0.
- Byte 0xA3 with stop bit driven 0 -> frame_err single pulse; rx_valid stays 0; rx_data unchanged (0x00 after reset).
- Bytes 0x12 then 0x34 back-to-back, rx_ready = 0 -> rx_data = 0x12, rx_valid = 1, overrun pulses once at the end of 0x34; raising rx_ready then clears rx_valid.
- 0x12 pending, rx_ready pulsed exactly on the cycle 0x34 completes -> rx_data = 0x34, rx_valid stays 1, no overrun.
- rstn asserted during data bit 4 of 0xFF, released, then 0x0F sent -> all outputs at reset values during reset; next delivered byte is 0x0F, no flags.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Receive-side sequencer for a UART bit-rate counter. Detects the
//             start bit, runs the rate counter through count_sig, samples rx on
//             each mid-bit bps_clk strobe (LSB first), checks the stop bit and
//             hands each character over through a one-entry valid/ready
//             holding register with framing-error and overrun pulses.
//  Ports    : clk        system clock
//             rstn       asynchronous active-low reset
//             rx         serial line (asynchronous, idles high)
//             bps_clk    one-cycle mid-bit strobe from the rate counter
//             count_sig  runs the rate counter (held at 0 while low)
//             rx_data    received character, right-aligned
//             rx_valid   rx_data holds an unconsumed character
//             rx_ready   consumer accepts rx_data this cycle
//             frame_err  one-cycle pulse: stop bit sampled low
//             overrun    one-cycle pulse: character dropped, holding reg full
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_BITS   = 8,  // 5..8
    parameter int SYNC_STAGES = 2   // >= 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic                 bps_clk,
    output logic                 count_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int                 c_cnt_w    = $clog2(DATA_BITS);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic [1:0]             r_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [c_cnt_w-1:0]     r_bit_cnt;

    logic w_rx_s;
    logic w_fall;
    logic w_stop_hit;
    logic w_deliver;
    logic w_load;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_stop_hit = (r_state == c_stop) & bps_clk;
    assign w_deliver  = w_stop_hit & w_rx_s;
    // A full holding register can still take the new character if the
    // consumer drains it in the same cycle.
    assign w_load     = w_deliver & (~rx_valid | rx_ready);

    // Synchronizer and edge-detect history; both reset to the idle-line level
    // so that reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

    // Frame sequencer. Edges outside IDLE and strobes in IDLE are ignored
    // simply because no other state reacts to them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= c_idle;
            count_sig <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_fall) begin
                        r_state   <= c_start;
                        count_sig <= 1'b1;
                    end
                end
                c_start: begin
                    if (bps_clk) begin
                        if (!w_rx_s) begin
                            r_state   <= c_data;
                            r_bit_cnt <= '0;
                        end else begin
                            // Line back high at mid start bit: a glitch.
                            r_state   <= c_idle;
                            count_sig <= 1'b0;
                        end
                    end
                end
                c_data: begin
                    if (bps_clk) begin
                        r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + c_one;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= c_stop;
                        end
                    end
                end
                c_stop: begin
                    if (bps_clk) begin
                        r_state   <= c_idle;
                        count_sig <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_idle;
                    count_sig <= 1'b0;
                end
            endcase
        end
    end

    // Holding register and status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_hit & ~w_rx_s;
            overrun   <= w_deliver & rx_valid & ~rx_ready;
            if (w_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl. Models the bit-rate counter
//             (first strobe HALF cycles after count_sig rises, then every BIT),
//             with a shortened bit period to keep runs small.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int BIT  = 64;
    localparam int HALF = 32;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       bps_clk;
    logic       count_sig;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       frame_err;
    logic       overrun;

    uart_rx_ctrl #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .bps_clk   (bps_clk),
        .count_sig (count_sig),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Rate counter model.
    int rc = 0;
    always @(posedge clk) begin
        if (!count_sig) rc <= 0;
        else            rc <= (rc == BIT - 1) ? 0 : rc + 1;
    end
    assign bps_clk = count_sig && (rc == HALF);

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Scoreboard and monitor.
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         vcyc = 0;

    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || rx_ready)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_delivery: got rx_data=%0h, required no delivery", rx_data);
                end else begin
                    check("scoreboard_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            fe_cnt += int'(frame_err);
            ov_cnt += int'(overrun);
            vcyc   += int'(rx_valid);
            prev_valid = rx_valid;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    // Returns at the negedge where the n-th strobe of the coming frame is high.
    task automatic wait_strobe(input int n, output bit hit);
        int cnt = 0;
        hit = 1'b0;
        for (int k = 0; k < 12 * BIT && !hit; k++) begin
            @(negedge clk);
            if (bps_clk) begin
                cnt++;
                if (cnt == n) hit = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       fe;
        logic       dlv;
        logic [7:0] data_after;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int fe0, ov0, v0;
        bit hit;

        tbl[0] = '{8'hA3, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55};
        tbl[2] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81};
        tbl[3] = '{8'hC6, 1'b0, 1'b1, 1'b0, 8'h81};
        tbl[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_count_sig", {31'd0, count_sig}, 32'd0);
        check("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("reset_rx_data",   {24'd0, rx_data},   32'd0);
        check("reset_flags",     {30'd0, frame_err, overrun}, 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven frames, consumer always ready
        for (int v = 0; v < 5; v++) begin
            fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
            rx_ready = 1'b1;
            if (tbl[v].dlv) exp_q.push_back(tbl[v].data);
            send_byte(tbl[v].data, tbl[v].stop);
            repeat (8) @(negedge clk);
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data}, {24'd0, tbl[v].data_after});
            check($sformatf("v%0d_frame_err", v), fe_cnt - fe0, {31'd0, tbl[v].fe});
            check($sformatf("v%0d_overrun", v), ov_cnt - ov0, 32'd0);
            check($sformatf("v%0d_valid_cycles", v), vcyc - v0, {31'd0, tbl[v].dlv});
            check($sformatf("v%0d_count_sig", v), {31'd0, count_sig}, 32'd0);
            check($sformatf("v%0d_rx_valid", v), {31'd0, rx_valid}, 32'd0);
            check($sformatf("v%0d_queue", v), exp_q.size(), 32'd0);
        end

        // Glitch shorter than half a bit; count_sig timing after the edge
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("edge_count_sig_low", {31'd0, count_sig}, 32'd0);
        @(posedge clk);
        #1 check("edge_count_sig_high", {31'd0, count_sig}, 32'd1);
        repeat (13) @(negedge clk);
        rx = 1'b1;
        repeat (HALF + 16) @(negedge clk);
        check("glitch_count_sig", {31'd0, count_sig}, 32'd0);
        check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
        check("glitch_valid", vcyc - v0, 32'd0);

        // Back-to-back 0x12, 0x34 with consumer stalled -> overrun on 0x34
        ov0 = ov_cnt; fe0 = fe_cnt;
        rx_ready = 1'b0;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (8) @(negedge clk);
        check("ovr_rx_data",  {24'd0, rx_data},  32'h12);
        check("ovr_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_pulses",   ov_cnt - ov0, 32'd1);
        check("ovr_no_fe",    fe_cnt - fe0, 32'd0);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_drain_valid", {31'd0, rx_valid}, 32'd0);

        // 0x12 pending; ready pulsed exactly on the 0x34 stop strobe
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        exp_q.push_back(8'h34);
        fork
            send_byte(8'h34, 1'b1);
            begin
                wait_strobe(10, hit);
                check("pulse_strobe_found", {31'd0, hit}, 32'd1);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (8) @(negedge clk);
        check("pulse_rx_data",  {24'd0, rx_data},  32'h34);
        check("pulse_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("pulse_no_overrun", ov_cnt - ov0, 32'd0);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("pulse_drain_valid", {31'd0, rx_valid}, 32'd0);

        // Reset during data bit 4 of 0xFF, then 0x0F
        fork
            send_byte(8'hFF, 1'b1);
            begin
                wait_strobe(6, hit);
                check("rst_strobe_found", {31'd0, hit}, 32'd1);
                rstn = 1'b0;
                #1;
                check("rst_count_sig", {31'd0, count_sig}, 32'd0);
                check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
                check("rst_rx_data",   {24'd0, rx_data},   32'd0);
                check("rst_flags",     {30'd0, frame_err, overrun}, 32'd0);
                repeat (3) @(negedge clk);
                rstn = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vcyc;
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        repeat (8) @(negedge clk);
        check("after_rst_rx_data", {24'd0, rx_data}, 32'h0F);
        check("after_rst_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
        check("after_rst_valid_cycles", vcyc - v0, 32'd1);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
